alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one combinational ALU (SrcA/SrcB/ALUControl -> ALUResult/Zero) between two requesters.
//  Round-robin grant, valid/ready request handshake, registered operands and registered response pulse.
//  Sits between the two requesting units and the ALU instance; the ALU stays a pure datapath.
// PARAMETERS
//  WIDTH  4  operand/result width; must match the ALU WIDTH
//  CNT_W  8  grant counter width (only with ALU_ARB_PERF_CNT_EN)
// PORTS
//  clk           in   1      single clock, rising edge
//  rst           in   1      asynchronous, active-high reset
//  reqN_valid    in   1      requester N (N=0,1) has an op
//  reqN_ready    out  1      arbiter accepts requester N this cycle
//  reqN_a/_b     in   WIDTH  operands A/B for requester N
//  reqN_op       in   3      ALU control code for requester N
//  rspN_valid    out  1      one-cycle result pulse to requester N
//  rspN_result   out  WIDTH  registered ALU result
//  rspN_zero     out  1      registered ALU Zero flag
//  alu_srca/_b   out  WIDTH  registered operands to the ALU
//  alu_ctrl      out  3      ALU control; park code 3'b111 when not executing
//  alu_result    in   WIDTH  ALU result (combinational from alu_* outputs)
//  alu_zero      in   1      ALU Zero flag
// BEHAVIOUR
//  - Reset: state IDLE, all outputs 0 except alu_ctrl=3'b111; last_grant=1 (req0 wins first tie).
//  - FSM IDLE -> EXEC -> IDLE. One op per 2 cycles max.
//  - IDLE: reqN_ready = grantN (combinational). Grant rules: only one valid -> that one; both valid ->
//    the one not equal to last_grant. Handshake = reqN_valid & reqN_ready at the edge.
//  - On handshake: latch a/b/op into alu_srca/alu_srcb/alu_ctrl, owner<=N, last_grant<=N, go EXEC.
//  - EXEC: ready=0 for both. At end of EXEC: rsp{owner}_result<=alu_result, rsp{owner}_zero<=alu_zero,
//    rsp{owner}_valid<=1 for exactly one cycle; alu_ctrl<=3'b111; go IDLE.
//  - Latency: accept at edge k -> rspN_valid high in cycle after edge k+1 (2 cycles). No rsp backpressure.
//  - The shared ALU re-evaluates only on ALUControl change; parking alu_ctrl at 3'b111 between ops
//    guarantees a control change every issue, including back-to-back identical op codes.
//  - rspN_result/rspN_zero hold their last value when rspN_valid=0; the other requester's rsp is untouched.
//  - Op codes forwarded unchecked; unsupported codes yield whatever the ALU returns (result 0).
//  - A request arriving during EXEC waits; valid must stay high and operands stable until ready.
//  - Width: operands/results are WIDTH bits, no extension; wrap-around is the ALU's.
//  - Reset mid-EXEC: op dropped, no rsp pulse, FSM to IDLE, last_grant=1.
// CONFIGURATION
//  ALU_ARB_PERF_CNT_EN defined: adds outputs grant_cnt0, grant_cnt1 [CNT_W-1:0]; +1 per handshake of
//    that requester, saturate at all-ones, reset to 0.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  - Single req0: a=9,b=8,op=000 -> ready same cycle; rsp0_valid 2 cycles later, result=1, zero=0.
//  - Both valid from reset, req0 a=3,b=3,op=001; req1 a=12,b=10,op=010 -> req0 first (result 0, zero=1),
//    req1 next grant (result 8, zero=0); no rsp1 pulse during req0's op.
//  - Both held valid 8 ops -> grants alternate 0,1,0,1...; each rsp pulse 1 cycle wide.
//  - req1 back-to-back op=101 (2,5 then 5,2) -> results 1 then 0; alu_ctrl observed 3'b111 between ops.
//  - rst asserted during EXEC -> no rsp pulse, all outputs 0, alu_ctrl=3'b111; next tie grants req0.
//  - ALU_ARB_PERF_CNT_EN, CNT_W=2: 5 req0 ops -> grant_cnt0=3 (saturated), grant_cnt1=0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between two requesters.
//   Round-robin grant, valid/ready request handshake, registered ALU operands
//   and a registered one-cycle response pulse per requester. The ALU itself
//   stays outside as a pure datapath. An operation occupies the ALU for two
//   cycles: IDLE (accept), then EXEC (capture result).
//
// Optional feature: define ALU_ARB_PERF_CNT_EN to add the saturating
//   per-requester grant counters grant_cnt0/grant_cnt1.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   reqN_valid/ready         request handshake for requester N (N=0,1)
//   reqN_a/_b/_op            operands and ALU control code of requester N
//   rspN_valid               one-cycle result pulse to requester N
//   rspN_result/_zero        registered result and Zero flag (hold between pulses)
//   alu_srca/_b/_ctrl        registered operands/control to the shared ALU
//   alu_result/_zero         combinational ALU response
//   grant_cnt0/1             grants per requester (ALU_ARB_PERF_CNT_EN only)

module alu_share_arbiter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_zero,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_zero,
  output logic [WIDTH-1:0] alu_srca,
  output logic [WIDTH-1:0] alu_srcb,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
`ifdef ALU_ARB_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
`endif
);

  // Parking code forces an ALUControl change on every issue, so the ALU
  // re-evaluates even for back-to-back identical op codes.
  localparam logic [2:0] PARK_CTRL = 3'b111;

  if (CNT_W < 1) begin : g_cnt_w_chk
    $error("alu_share_arbiter: CNT_W must be at least 1");
  end

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  state_t state;
  logic   owner;       // requester whose op is in EXEC
  logic   last_grant;  // requester granted most recently
  logic   grant0;
  logic   grant1;

  // Round-robin: a lone requester wins; on a tie the one not granted last wins.
  assign grant0 = (state == IDLE) && req0_valid && (!req1_valid || last_grant);
  assign grant1 = (state == IDLE) && req1_valid && (!req0_valid || !last_grant);

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Arbiter FSM with registered ALU drive and response capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_grant  <= 1'b1;
      alu_srca    <= '0;
      alu_srcb    <= '0;
      alu_ctrl    <= PARK_CTRL;
      rsp0_valid  <= 1'b0;
      rsp0_result <= '0;
      rsp0_zero   <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp1_result <= '0;
      rsp1_zero   <= 1'b0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant0) begin
            alu_srca   <= req0_a;
            alu_srcb   <= req0_b;
            alu_ctrl   <= req0_op;
            owner      <= 1'b0;
            last_grant <= 1'b0;
            state      <= EXEC;
          end else if (grant1) begin
            alu_srca   <= req1_a;
            alu_srcb   <= req1_b;
            alu_ctrl   <= req1_op;
            owner      <= 1'b1;
            last_grant <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          if (owner) begin
            rsp1_valid  <= 1'b1;
            rsp1_result <= alu_result;
            rsp1_zero   <= alu_zero;
          end else begin
            rsp0_valid  <= 1'b1;
            rsp0_result <= alu_result;
            rsp0_zero   <= alu_zero;
          end
          alu_ctrl <= PARK_CTRL;
          state    <= IDLE;
        end
      endcase
    end
  end

`ifdef ALU_ARB_PERF_CNT_EN
  // Saturating grant counters, one step per accepted handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (grant0 && (grant_cnt0 != '1)) begin
        grant_cnt0 <= grant_cnt0 + CNT_W'(1);
      end
      if (grant1 && (grant_cnt1 != '1)) begin
        grant_cnt1 <= grant_cnt1 + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural 4-bit ALU
// (000 add, 001 sub, 010 and, 011 or, 101 signed slt, others 0).
module tb_alu_share_arbiter;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 2;

  logic             clk;
  logic             rst;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]       req0_op, req1_op;
  logic             rsp0_valid, rsp1_valid;
  logic [WIDTH-1:0] rsp0_result, rsp1_result;
  logic             rsp0_zero, rsp1_zero;
  logic [WIDTH-1:0] alu_srca, alu_srcb, alu_result;
  logic [2:0]       alu_ctrl;
  logic             alu_zero;
`ifdef ALU_ARB_PERF_CNT_EN
  logic [CNT_W-1:0] grant_cnt0, grant_cnt1;
`endif

  int total = 0;
  int bad   = 0;

  alu_share_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp0_valid (rsp0_valid),
    .rsp0_result(rsp0_result),
    .rsp0_zero  (rsp0_zero),
    .rsp1_valid (rsp1_valid),
    .rsp1_result(rsp1_result),
    .rsp1_zero  (rsp1_zero),
    .alu_srca   (alu_srca),
    .alu_srcb   (alu_srcb),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_zero   (alu_zero)
`ifdef ALU_ARB_PERF_CNT_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  // External combinational ALU.
  always_comb begin
    case (alu_ctrl)
      3'b000:  alu_result = alu_srca + alu_srcb;
      3'b001:  alu_result = alu_srca - alu_srcb;
      3'b010:  alu_result = alu_srca & alu_srcb;
      3'b011:  alu_result = alu_srca | alu_srcb;
      3'b101:  alu_result = ($signed(alu_srca) < $signed(alu_srcb)) ? 4'd1 : 4'd0;
      default: alu_result = 4'd0;
    endcase
  end
  assign alu_zero = (alu_result == 4'd0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Issue one op from requester n, wait (bounded) for its pulse, check result.
  task automatic issue_op(input int n, input logic [3:0] a, input logic [3:0] b,
                          input logic [2:0] op, input logic [3:0] er, input logic ez);
    int   k;
    logic seen;
    if (n == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end
    #1;
    k = 0;
    while (!((n == 0) ? req0_ready : req1_ready) && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("iss_ready", 32'((n == 0) ? req0_ready : req1_ready), 1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge clk);
      if ((n == 0) ? rsp0_valid : rsp1_valid) seen = 1'b1;
    end
    chk("iss_rsp", 32'(seen), 1);
    chk("iss_result", 32'((n == 0) ? rsp0_result : rsp1_result), 32'(er));
    chk("iss_zero", 32'((n == 0) ? rsp0_zero : rsp1_zero), 32'(ez));
  endtask

  int   pulses;
  logic exp_owner;
  logic prev_pulse;
  logic p0, p1;

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;

    // Reset state
    @(negedge clk);
    chk("rst_ctrl", 32'(alu_ctrl), 7);
    chk("rst_srca", 32'(alu_srca), 0);
    chk("rst_srcb", 32'(alu_srcb), 0);
    chk("rst_rsp0v", 32'(rsp0_valid), 0);
    chk("rst_rsp1v", 32'(rsp1_valid), 0);
    chk("rst_rsp0r", 32'(rsp0_result), 0);
    chk("rst_ready0", 32'(req0_ready), 0);
    rst = 1'b0;

    // Single req0: 9+8 wraps to 1
    req0_valid = 1'b1; req0_a = 4'd9; req0_b = 4'd8; req0_op = 3'b000;
    #1;
    chk("t1_ready0", 32'(req0_ready), 1);
    chk("t1_ready1", 32'(req1_ready), 0);
    @(negedge clk);
    chk("t1_exec_ctrl", 32'(alu_ctrl), 0);
    chk("t1_exec_srca", 32'(alu_srca), 9);
    chk("t1_exec_srcb", 32'(alu_srcb), 8);
    chk("t1_exec_ready", 32'(req0_ready), 0);
    chk("t1_exec_rsp0v", 32'(rsp0_valid), 0);
    req0_valid = 1'b0;
    @(negedge clk);
    chk("t1_rsp0v", 32'(rsp0_valid), 1);
    chk("t1_result", 32'(rsp0_result), 1);
    chk("t1_zero", 32'(rsp0_zero), 0);
    chk("t1_park", 32'(alu_ctrl), 7);
    chk("t1_rsp1v", 32'(rsp1_valid), 0);
    @(negedge clk);
    chk("t1_pulse_end", 32'(rsp0_valid), 0);
    chk("t1_hold", 32'(rsp0_result), 1);

    // Tie from reset: req0 first, then req1
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req0_valid = 1'b1; req0_a = 4'd3;  req0_b = 4'd3;  req0_op = 3'b001;
    req1_valid = 1'b1; req1_a = 4'd12; req1_b = 4'd10; req1_op = 3'b010;
    #1;
    chk("t2_ready0", 32'(req0_ready), 1);
    chk("t2_ready1", 32'(req1_ready), 0);
    @(negedge clk);
    chk("t2_exec_ctrl", 32'(alu_ctrl), 1);
    chk("t2_exec_ready1", 32'(req1_ready), 0);
    chk("t2_exec_rsp1v", 32'(rsp1_valid), 0);
    req0_valid = 1'b0;
    @(negedge clk);
    chk("t2_rsp0v", 32'(rsp0_valid), 1);
    chk("t2_rsp0_result", 32'(rsp0_result), 0);
    chk("t2_rsp0_zero", 32'(rsp0_zero), 1);
    chk("t2_rsp1v_quiet", 32'(rsp1_valid), 0);
    chk("t2_ready1", 32'(req1_ready), 1);
    @(negedge clk);
    chk("t2_exec1_ctrl", 32'(alu_ctrl), 2);
    chk("t2_exec1_srca", 32'(alu_srca), 12);
    req1_valid = 1'b0;
    @(negedge clk);
    chk("t2_rsp1v", 32'(rsp1_valid), 1);
    chk("t2_rsp1_result", 32'(rsp1_result), 8);
    chk("t2_rsp1_zero", 32'(rsp1_zero), 0);
    chk("t2_rsp0_untouched_r", 32'(rsp0_result), 0);
    chk("t2_rsp0_untouched_z", 32'(rsp0_zero), 1);
    chk("t2_rsp0v_quiet", 32'(rsp0_valid), 0);

    // Both held valid for 8 ops: grants alternate starting with req0
    req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd2; req0_op = 3'b000;
    req1_valid = 1'b1; req1_a = 4'd7; req1_b = 4'd7; req1_op = 3'b001;
    pulses = 0;
    exp_owner = 1'b0;
    prev_pulse = 1'b0;
    for (int i = 0; i < 40 && pulses < 8; i++) begin
      @(negedge clk);
      p0 = rsp0_valid;
      p1 = rsp1_valid;
      if (p0 || p1) begin
        chk("alt_single", 32'(p0 & p1), 0);
        chk("alt_owner", 32'(p1), 32'(exp_owner));
        chk("alt_width", 32'(prev_pulse), 0);
        chk("alt_result", 32'(p1 ? rsp1_result : rsp0_result), exp_owner ? 0 : 3);
        chk("alt_zero", 32'(p1 ? rsp1_zero : rsp0_zero), exp_owner ? 1 : 0);
        exp_owner = ~exp_owner;
        pulses++;
        if (pulses == 8) begin
          req0_valid = 1'b0;
          req1_valid = 1'b0;
        end
      end
      prev_pulse = p0 | p1;
    end
    chk("alt_count", 32'(pulses), 8);
    @(negedge clk);
    chk("alt_tail0", 32'(rsp0_valid), 0);
    chk("alt_tail1", 32'(rsp1_valid), 0);

    // req1 back-to-back slt: 2<5 -> 1, 5<2 -> 0, parked between
    req1_valid = 1'b1; req1_a = 4'd2; req1_b = 4'd5; req1_op = 3'b101;
    @(negedge clk);
    chk("b2b_ctrl1", 32'(alu_ctrl), 5);
    @(negedge clk);
    chk("b2b_rsp1v_a", 32'(rsp1_valid), 1);
    chk("b2b_result_a", 32'(rsp1_result), 1);
    chk("b2b_zero_a", 32'(rsp1_zero), 0);
    chk("b2b_park", 32'(alu_ctrl), 7);
    req1_a = 4'd5; req1_b = 4'd2;
    @(negedge clk);
    chk("b2b_ctrl2", 32'(alu_ctrl), 5);
    chk("b2b_srca2", 32'(alu_srca), 5);
    req1_valid = 1'b0;
    @(negedge clk);
    chk("b2b_rsp1v_b", 32'(rsp1_valid), 1);
    chk("b2b_result_b", 32'(rsp1_result), 0);
    chk("b2b_zero_b", 32'(rsp1_zero), 1);

    // Reset during req0's EXEC: op dropped, next tie goes to req0
    req0_valid = 1'b1; req0_a = 4'd4; req0_b = 4'd4; req0_op = 3'b000;
    @(negedge clk);
    chk("rx_in_exec", 32'(alu_ctrl), 0);
    req0_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rx_ctrl", 32'(alu_ctrl), 7);
    chk("rx_srca", 32'(alu_srca), 0);
    chk("rx_rsp0r", 32'(rsp0_result), 0);
    chk("rx_rsp1r", 32'(rsp1_result), 0);
    chk("rx_rsp1z", 32'(rsp1_zero), 0);
    @(negedge clk);
    chk("rx_no_pulse0", 32'(rsp0_valid), 0);
    chk("rx_no_pulse1", 32'(rsp1_valid), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rx_no_pulse0b", 32'(rsp0_valid), 0);
    req0_valid = 1'b1; req0_a = 4'd6; req0_b = 4'd3; req0_op = 3'b011;
    req1_valid = 1'b1; req1_a = 4'd1; req1_b = 4'd1; req1_op = 3'b000;
    #1;
    chk("rx_tie_ready0", 32'(req0_ready), 1);
    chk("rx_tie_ready1", 32'(req1_ready), 0);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    chk("rx_rsp0v", 32'(rsp0_valid), 1);
    chk("rx_result", 32'(rsp0_result), 7);

    // Unsupported op code: ALU returns 0
    issue_op(1, 4'd9, 4'd3, 3'b110, 4'd0, 1'b1);

`ifdef ALU_ARB_PERF_CNT_EN
    // Grant counters saturate at all-ones (CNT_W=2)
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("cnt_rst0", 32'(grant_cnt0), 0);
    chk("cnt_rst1", 32'(grant_cnt1), 0);
    for (int i = 0; i < 5; i++) begin
      issue_op(0, 4'd1, 4'd1, 3'b000, 4'd2, 1'b0);
    end
    chk("cnt_sat0", 32'(grant_cnt0), 3);
    chk("cnt_idle1", 32'(grant_cnt1), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
